// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx_FSM transmitter between NREQ byte
// requesters. It frames the granted byte as {stop, data, start}, issues a
// one-cycle tx_start, then counts baud ticks until the line is free again,
// because the transmitter has no busy or done output of its own.
//
// Build option: define UART_TX_ARB_FIXED_PRIO_EN to select fixed priority
// (lowest-index requester wins, no rotating pointer). If it is left undefined,
// the arbiter uses round-robin.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,   // 2..8 requesters
  parameter int FRAME_TICKS = 11   // 10..15 baud ticks per frame, slack included
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              tx_start,
  output logic [9:0]        tx_data
);

  localparam int         IW        = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LAST_TICK = 4'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      tick_cnt;     // baud ticks seen in WAIT; stops at LAST_TICK
  logic            pick_valid;
  logic [IW-1:0]   pick;
  logic [NREQ-1:0] pick_onehot;
  logic [7:0]      pick_byte;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  localparam logic [IW-1:0] LAST_CH = IW'(NREQ - 1);

  logic [IW-1:0] ptr;            // first channel searched at the next arbitration
  logic [IW-1:0] owner;          // channel holding the transmitter

  // Rotating search: first asserted request at or after ptr, wrapping past NREQ-1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned and no latch appears.
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
      end
    end
  end
`else
  // Fixed priority: the lowest-index asserted request wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_valid = 1'b1;
        pick       = IW'(i);
      end
    end
  end
`endif

  // One-hot form of the winner, used for both grant and ack.
  always_comb begin
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
  end

  assign pick_byte = req_data[8*pick +: 8];

  // Arbitration and frame sequencing. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      ack      <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 10'h3FF;       // idle line level until the first frame
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      ptr      <= '0;
      owner    <= '0;
`endif
    end else begin
      // NOTE: clocked state uses non-blocking assignments only. Every register
      // then updates from values sampled at the same edge, whatever the
      // statement order below.
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant    <= pick_onehot;
            ack      <= pick_onehot;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            tx_data  <= {1'b1, pick_byte, 1'b0};
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            owner    <= pick;
`endif
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A tick here is ignored. The transmitter aligns tx_start to its next
          // tick itself, and the slack tick in FRAME_TICKS covers that delay.
          tick_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_en) begin
            if (tick_cnt == LAST_TICK) begin
              grant <= '0;
              busy  <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
              ptr   <= (owner == LAST_CH) ? '0 : owner + IW'(1);
`endif
              state <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A frame-level reference model
// (tick countdown, modulo pointer search) predicts every output on every
// cycle. Scenario tasks add their own checks on top of that model.
module tb_uart_tx_arbiter;

  localparam int NREQ        = 4;
  localparam int FRAME_TICKS = 11;

  logic              clk;
  logic              rst;
  logic              tx_en;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              tx_start;
  logic [9:0]        tx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_total = 0;
  int gap_left = 2;

  // Reference model
  bit         m_busy  = 1'b0;
  bit         m_fresh = 1'b0;   // the cycle right after a grant: start pulse expected
  int         m_owner = 0;
  int         m_ptr   = 0;
  int         m_left  = 0;      // baud ticks still owed to the current frame
  logic [9:0] m_frame = 10'h3FF;

  // Observation logs
  int         log_ch[$];
  int         log_cyc[$];
  int         log_tick[$];
  int         log_load_tick[$];
  logic [9:0] log_data[$];
  int         fall_tick[$];
  bit         prev_busy = 1'b0;

  uart_tx_arbiter #(.NREQ(NREQ), .FRAME_TICKS(FRAME_TICKS)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .busy(busy), .tx_start(tx_start), .tx_data(tx_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int off = 0; off < NREQ; off++) begin
      int c;
      c = (ptr + off) % NREQ;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic int onehot_index(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  // Advance one clock: update the model for this edge, then compare the DUT
  // outputs shortly after the edge, log events, and drive the next baud tick.
  task automatic step();
    int w;
    logic [NREQ-1:0] e_grant;
    logic [NREQ-1:0] e_ack;
    if (rst) begin
      m_busy = 1'b0; m_fresh = 1'b0; m_ptr = 0; m_frame = 10'h3FF;
    end else if (!m_busy) begin
      w = model_pick(req, m_ptr);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_fresh = 1'b1;
        m_owner = w;
        m_frame = {1'b1, req_data[8*w +: 8], 1'b0};
        m_left  = FRAME_TICKS;
        m_ptr   = (w + 1) % NREQ;
      end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (tx_en) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    if (tx_en) tick_total++;

    @(posedge clk);
    #1;
    cyc++;

    e_grant = '0;
    e_ack   = '0;
    if (m_busy)  e_grant[m_owner] = 1'b1;
    if (m_fresh) e_ack[m_owner]   = 1'b1;
    checks += 5;
    if (grant !== e_grant) begin
      errors++; $display("FAIL grant @%0d: got %b expected %b", cyc, grant, e_grant);
    end
    if (ack !== e_ack) begin
      errors++; $display("FAIL ack @%0d: got %b expected %b", cyc, ack, e_ack);
    end
    if (busy !== m_busy) begin
      errors++; $display("FAIL busy @%0d: got %b expected %b", cyc, busy, m_busy);
    end
    if (tx_start !== m_fresh) begin
      errors++; $display("FAIL tx_start @%0d: got %b expected %b", cyc, tx_start, m_fresh);
    end
    if (tx_data !== m_frame) begin
      errors++; $display("FAIL tx_data @%0d: got %h expected %h", cyc, tx_data, m_frame);
    end

    if (prev_busy && busy === 1'b0) fall_tick.push_back(tick_total);
    prev_busy = (busy === 1'b1);

    if (gap_left == 0) begin
      tx_en = 1'b1;
      gap_left = $urandom_range(1, 3);
    end else begin
      tx_en = 1'b0;
      gap_left--;
    end

    if (tx_start === 1'b1) begin
      log_ch.push_back(onehot_index(ack));
      log_cyc.push_back(cyc);
      log_tick.push_back(tick_total);
      log_load_tick.push_back(int'(tx_en));
      log_data.push_back(tx_data);
    end
  endtask

  task automatic clear_logs();
    log_ch.delete(); log_cyc.delete(); log_tick.delete();
    log_load_tick.delete(); log_data.delete(); fall_tick.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s idle timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic wait_starts(input int target, input int bound, input string name);
    int n = 0;
    while (log_ch.size() < target && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (log_ch.size() < target) begin
      errors++; $display("FAIL %s start timeout: %0d starts, want %0d", name, log_ch.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'($urandom_range(1, 15));
    req_data = $urandom;
    step();
    step();
    rst = 1'b0;
    req = '0;
    checks += 5;
    if (ack !== '0)       begin errors++; $display("FAIL reset ack: got %b expected 0", ack); end
    if (grant !== '0)     begin errors++; $display("FAIL reset grant: got %b expected 0", grant); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset tx_start: got %b expected 0", tx_start); end
    if (tx_data !== 10'h3FF) begin errors++; $display("FAIL reset tx_data: got %h expected 3ff", tx_data); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle after reset: busy got %b expected 0", busy); end
    clear_logs();
  endtask

  task automatic test_single_byte();
    logic [9:0] f;
    logic [7:0] d;
    apply_reset();
    req_data = $urandom;
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    checks += 3;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL single tx_start: got %b expected 1", tx_start); end
    if (ack !== 4'b0100)   begin errors++; $display("FAIL single ack: got %b expected 0100", ack); end
    if (tx_data !== 10'h34A) begin errors++; $display("FAIL single tx_data: got %h expected 34a", tx_data); end
    req = '0;
    step();
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL single pulse width: tx_start got %b expected 0", tx_start); end
    wait_idle(400, "single");
    checks += 2;
    if (log_ch.size() != 1) begin
      errors++; $display("FAIL single start count: got %0d expected 1", log_ch.size());
    end
    if (fall_tick.size() != 1 || log_tick.size() != 1) begin
      errors++; $display("FAIL single busy fall: falls %0d starts %0d, expected 1 and 1", fall_tick.size(), log_tick.size());
    end else if (fall_tick[0] - log_tick[0] != FRAME_TICKS + log_load_tick[0]) begin
      errors++; $display("FAIL single busy fall ticks: got %0d expected %0d",
                         fall_tick[0] - log_tick[0], FRAME_TICKS + log_load_tick[0]);
    end
    // Decode the frame the way the line carries it: bit 0 first.
    f = (log_data.size() > 0) ? log_data[0] : 10'h3FF;
    d = '0;
    for (int i = 1; i <= 8; i++) d[i-1] = f[i];
    checks += 3;
    if (f[0] !== 1'b0) begin errors++; $display("FAIL single start bit: got %b expected 0", f[0]); end
    if (f[9] !== 1'b1) begin errors++; $display("FAIL single stop bit: got %b expected 1", f[9]); end
    if (d !== 8'hA5)   begin errors++; $display("FAIL single decoded byte: got %h expected a5", d); end
  endtask

  task automatic test_all_requests();
    int exp_order[5];
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'hF;
    wait_starts(5, 600, "all");
    req = '0;
    wait_idle(400, "all");
    for (int k = 0; k < 5 && k < log_ch.size(); k++) begin
      checks += 2;
      if (log_ch[k] != exp_order[k]) begin
        errors++; $display("FAIL all order[%0d]: got %0d expected %0d", k, log_ch[k], exp_order[k]);
      end
      if (log_data[k] !== {1'b1, 8'(8'h10 + exp_order[k]), 1'b0}) begin
        errors++; $display("FAIL all frame[%0d]: got %h expected %h", k, log_data[k],
                           {1'b1, 8'(8'h10 + exp_order[k]), 1'b0});
      end
    end
    for (int k = 1; k < log_ch.size(); k++) begin
      checks += 2;
      if (log_tick[k] - log_tick[k-1] < FRAME_TICKS) begin
        errors++; $display("FAIL all spacing ticks[%0d]: got %0d expected >= %0d", k,
                           log_tick[k] - log_tick[k-1], FRAME_TICKS);
      end
      if (log_cyc[k] - log_cyc[k-1] < FRAME_TICKS + 2) begin
        errors++; $display("FAIL all spacing cycles[%0d]: got %0d expected >= %0d", k,
                           log_cyc[k] - log_cyc[k-1], FRAME_TICKS + 2);
      end
    end
  endtask

  task automatic test_pointer_wrap();
    int exp_order[3];
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_order = '{3, 0, 0};
`else
    exp_order = '{3, 0, 3};
`endif
    apply_reset();
    req_data = $urandom;
    req = 4'b1000;
    wait_starts(1, 50, "wrap first");
    req = '0;
    wait_idle(400, "wrap first");
    req = 4'b1001;
    wait_starts(3, 600, "wrap");
    req = '0;
    wait_idle(400, "wrap");
    for (int k = 0; k < 3 && k < log_ch.size(); k++) begin
      checks++;
      if (log_ch[k] != exp_order[k]) begin
        errors++; $display("FAIL wrap order[%0d]: got %0d expected %0d", k, log_ch[k], exp_order[k]);
      end
    end
  endtask

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  task automatic test_fixed_priority();
    apply_reset();
    req_data = $urandom;
    req = 4'b0110;
    wait_starts(4, 800, "fixed");
    req = '0;
    wait_idle(400, "fixed");
    for (int k = 0; k < log_ch.size(); k++) begin
      checks++;
      if (log_ch[k] != 1) begin
        errors++; $display("FAIL fixed winner[%0d]: got %0d expected 1", k, log_ch[k]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int n = 0;
    logic [7:0] b;
    apply_reset();
    req_data = $urandom;
    req = 4'b0001;
    wait_starts(1, 50, "midreset");
    req = '0;
    while (m_left != FRAME_TICKS - 5 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midreset in WAIT: busy got %b expected 1", busy);
    end
    b = 8'($urandom);
    req_data[15:8] = b;
    req = 4'b0010;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 5;
    if (busy !== 1'b0)       begin errors++; $display("FAIL midreset busy: got %b expected 0", busy); end
    if (grant !== '0)        begin errors++; $display("FAIL midreset grant: got %b expected 0", grant); end
    if (tx_data !== 10'h3FF) begin errors++; $display("FAIL midreset tx_data: got %h expected 3ff", tx_data); end
    if (ack !== '0)          begin errors++; $display("FAIL midreset ack: got %b expected 0", ack); end
    if (tx_start !== 1'b0)   begin errors++; $display("FAIL midreset tx_start: got %b expected 0", tx_start); end
    step();
    checks += 2;
    if (ack !== 4'b0010) begin errors++; $display("FAIL midreset regrant ack: got %b expected 0010", ack); end
    if (tx_data !== {1'b1, b, 1'b0}) begin
      errors++; $display("FAIL midreset regrant tx_data: got %h expected %h", tx_data, {1'b1, b, 1'b0});
    end
    req = '0;
    wait_idle(400, "midreset");
  endtask

  task automatic test_request_during_wait();
    int n = 0;
    apply_reset();
    req_data = $urandom;
    req = 4'b0100;
    wait_starts(1, 50, "duringwait");
    req = '0;
    while (m_left > FRAME_TICKS - 3 && n < 200) begin
      step();
      n++;
    end
    req = 4'b0001;
    step();
    step();
    req = 4'b0011;
    step();
    req = 4'b0001;
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL duringwait still WAIT: busy got %b expected 1", busy); end
    wait_idle(400, "duringwait");
    checks++;
    if (log_ch.size() != 1) begin
      errors++; $display("FAIL duringwait early grant: starts %0d expected 1", log_ch.size());
    end
    wait_starts(2, 50, "duringwait second");
    req = '0;
    wait_idle(400, "duringwait second");
    checks += 2;
    if (log_ch.size() != 2) begin
      errors++; $display("FAIL duringwait start count: got %0d expected 2", log_ch.size());
    end
    if (log_ch.size() >= 2 && log_ch[1] != 0) begin
      errors++; $display("FAIL duringwait second winner: got %0d expected 0", log_ch[1]);
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] bytes[NREQ][4];
    int cnt[NREQ];
    int idx[NREQ];
    int delay[NREQ];
    int total = 0;
    int sent  = 0;
    bit done;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]   = $urandom_range(1, 4);
      idx[i]   = 0;
      delay[i] = $urandom_range(0, 60);
      total   += cnt[i];
      for (int j = 0; j < 4; j++) bytes[i][j] = 8'($urandom);
    end
    req_data = $urandom;
    for (int t = 0; t < 5000; t++) begin
      done = (req == '0) && (busy === 1'b0);
      for (int i = 0; i < NREQ; i++) if (idx[i] < cnt[i]) done = 1'b0;
      if (done) break;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] === 1'b1) begin
          checks++;
          if (idx[i] >= cnt[i]) begin
            errors++; $display("FAIL random extra ack ch%0d: got %0d acks expected %0d", i, idx[i] + 1, cnt[i]);
          end else if (tx_data !== {1'b1, bytes[i][idx[i]], 1'b0}) begin
            errors++; $display("FAIL random frame ch%0d: got %h expected %h", i, tx_data,
                               {1'b1, bytes[i][idx[i]], 1'b0});
          end
          idx[i]++;
          sent++;
          if (idx[i] < cnt[i]) req_data[8*i +: 8] = bytes[i][idx[i]];
          else req[i] = 1'b0;
        end else if (req[i] == 1'b0 && idx[i] < cnt[i] && t >= delay[i]) begin
          req_data[8*i +: 8] = bytes[i][idx[i]];
          req[i] = 1'b1;
        end
      end
    end
    checks += 2;
    if (sent != total) begin errors++; $display("FAIL random byte count: got %0d expected %0d", sent, total); end
    if (busy !== 1'b0) begin errors++; $display("FAIL random drain: busy got %b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    req = '0;
    req_data = '0;
    test_reset();
    test_single_byte();
    test_all_requests();
    test_pointer_wrap();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    test_fixed_priority();
`endif
    test_reset_mid_frame();
    test_request_during_wait();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx_FSM` transmitter between `NREQ` byte requesters. It sits between the requesting logic and the transmitter, and runs on the same 100 MHz clock and free-running baud tick. It frames the granted byte, issues a single-cycle `tx_start`, and counts baud ticks to know when the line is free again, because the transmitter has no busy/done output. The arbitration policy is round-robin by default, or fixed priority under a compile switch.

## Interface
- `NREQ`, 4 — number of requesters; legal range 2..8.
- `FRAME_TICKS`, 11 — baud ticks the arbiter waits after `tx_start` before the next arbitration; 10 frame bits plus 1 tick of start-to-tick slack. Legal range 10..15.
- `clk` input 1 — 100 MHz system clock; all logic on its rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `tx_en` input 1 — baud tick, one `clk` cycle wide, shared with the transmitter.
- `req` input `NREQ` — per-requester level request.
- `req_data` input `8*NREQ` — byte `i` on `req_data[8*i+7:8*i]`; must be stable while `req[i]` is high.
- `ack` output `NREQ` — one-hot, one-cycle pulse; the byte has been taken.
- `grant` output `NREQ` — one-hot owner of the transmitter; zero when idle.
- `busy` output 1 — high whenever the state is not IDLE.
- `tx_start` output 1 — one-cycle start pulse to the transmitter.
- `tx_data` output 10 — frame to the transmitter, `{1'b1, byte[7:0], 1'b0}`; bit 0 (start) is shifted first.

## Operation
- The state machine has three states: IDLE, LOAD and WAIT.
- **IDLE:**
  - If `req` is nonzero, select the winner, register its byte into `tx_data` and set `grant`, then go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:** lasts exactly one cycle.
  - `tx_start` = 1 and `ack[winner]` = 1.
  - Clear the tick counter, then go to WAIT.
- **WAIT:**
  - Increment the tick counter on each `tx_en`.
  - When `tx_en` arrives with the counter at `FRAME_TICKS-1`, clear `grant`, advance the pointer, and go to IDLE.
- **Round-robin:**
  - Search order starts at the pointer and wraps from `NREQ-1` to 0.
  - After a grant to channel `w`, the pointer becomes `(w+1) mod NREQ`.
  - Reset sets the pointer to 0.
- **Requester handshake:**
  - Drop `req` or present the next byte in the cycle after `ack`.
  - A `req` still high after `ack` is treated as a new request and competes in the next arbitration.
- **Fairness:** a requester rising during WAIT is only considered at the next IDLE. Requests are never lost, since `req` is a level.
- `tx_data` holds its value from LOAD through WAIT. The arbiter never changes it while a frame is in flight.
- **Counter width:** 4 bits. It counts only in WAIT and saturates at `FRAME_TICKS-1`, with no wrap.

## Timing
- **Reset values:**
  - `ack`, `grant` and the pointer = 0.
  - `busy` and `tx_start` = 0.
  - `tx_data` = 10'h3FF, the idle line.
  - State = IDLE.
- **Latency:** `req` high in IDLE at cycle n gives `grant` and `busy` at n+1 and `tx_start`/`ack` at n+1. The LOAD outputs are registered from the IDLE decision.
- **Minimum spacing** between consecutive `tx_start` pulses: `FRAME_TICKS` baud ticks plus 2 `clk` cycles.
- **`tx_en` during LOAD:** not counted. The transmitter aligns `tx_start` to the next tick itself, and the extra slack tick covers this.
- **Simultaneous requests in IDLE:** exactly one grant goes to the first set bit from the pointer.
- **`rst` asserted in any state:** outputs return to reset values at the next edge.
  - An in-flight frame is abandoned by the arbiter. The transmitter must be reset by the same `rst`.
  - No `ack` is issued after reset.
- **`req` dropped during LOAD/WAIT:** no effect, because the byte was already latched.

## Configuration
- **`UART_TX_ARB_FIXED_PRIO_EN` defined:** fixed priority. The lowest-index asserted `req` always wins, and the pointer logic is removed.
- **Not defined (default):** round-robin as described above.

## Test plan
- **Single byte:** `req[2]`=1 with byte 8'hA5 in IDLE.
  - One `ack[2]` and one `tx_start` pulse.
  - `tx_data` = 10'h34A.
  - `busy` falls exactly 11 ticks later.
  - The serial line decodes as 0xA5.
- **All requests:** `req`=4'hF held, bytes 8'h10..8'h13.
  - Grant order is 0,1,2,3,0.
  - Spacing between `tx_start` pulses is at least 11 ticks plus 2 cycles.
  - There are no overlapping `grant` bits.
- **Pointer wrap:** after a grant to 3, assert `req`=4'b1001.
  - The grant goes to 0.
  - Then, with 4'b1001 still held, the grant goes to 3.
- **Fixed priority:** with `UART_TX_ARB_FIXED_PRIO_EN` defined and `req`=4'b0110 held, channel 1 is granted repeatedly and channel 2 is never granted.
- **Reset mid-frame:** assert `rst` for 1 cycle after 5 ticks in WAIT.
  - Next cycle: `busy`=0, `grant`=0, `tx_data`=10'h3FF.
  - A pending `req` is granted normally afterwards.
- **Request during WAIT:**
  - `req[0]` rises mid-WAIT and is granted only after WAIT completes.
  - `req[1]` pulsed for one cycle during WAIT is not granted, because it was dropped before IDLE.
